// File: rtl/uncached_bus_master_pkg.sv
// uncached_bus_master_pkg: state encoding, access-size codes and big-endian lane helpers
// shared by the uncached bus master and the cache write-back path.
package uncached_bus_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_BEGIN,
        S_WDATA,
        S_WEND,
        S_RWAIT,
        S_DONE,
        S_ERROR
    } ubmState_t;

    localparam logic [1:0] SIZE_ILLEGAL = 2'b00;
    localparam logic [1:0] SIZE_BYTE    = 2'b01;
    localparam logic [1:0] SIZE_HALF    = 2'b10;
    localparam logic [1:0] SIZE_WORD    = 2'b11;

    // Lane 3 carries the lowest byte address (big-endian bus).
    function automatic logic [3:0] byteEnables(input logic [1:0] size, input logic [1:0] addrLow);
        return size == SIZE_BYTE ? 4'b1000 >> addrLow :
               size == SIZE_HALF ? (addrLow[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    endfunction

    function automatic logic [31:0] replicateData(input logic [1:0] size, input logic [31:0] data);
        return size == SIZE_BYTE ? {4{data[7:0]}} :
               size == SIZE_HALF ? {2{data[15:0]}} : data;
    endfunction

endpackage

// File: rtl/uncached_bus_master.sv
// uncached_bus_master: single-beat uncached load/store sequencer for the shared processor bus.
// Define UBM_BUS_TIMEOUT_EN to abort WDATA/RWAIT after TIMEOUT_CYCLES cycles without slave progress.
module uncached_bus_master
    import uncached_bus_master_pkg::*;
`ifdef UBM_BUS_TIMEOUT_EN
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic        startRead,
    input  logic        startWrite,
    input  logic [31:0] accessAddress,
    input  logic [1:0]  accessSize,
    input  logic [31:0] writeData,
    output logic        cpuBusy,
    output logic        cpuDone,
    output logic        cpuError,
    output logic [31:0] readData,
    output logic        requestBus,
    input  logic        busAccessGranted,
    output logic        beginTransactionOut,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic        readNotWriteOut,
    output logic [7:0]  burstSizeOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    input  logic        busErrorIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busyIn,
    input  logic [31:0] addressDataIn
);

    ubmState_t   state;
    logic [31:0] address;
    logic [31:0] wordData;
    logic [3:0]  lanes;
    logic        isRead;
    logic        gotData;
    logic        aborted;
    logic        badStart;
    logic        readFail;
    logic        wendFail;
    logic        timedOut;

    assign badStart = accessSize == SIZE_ILLEGAL
                   || (accessSize == SIZE_HALF && accessAddress[0])
                   || (accessSize == SIZE_WORD && accessAddress[1:0] != 2'b00);
    assign readFail = busErrorIn || (endTransactionIn && !gotData && !dataValidIn);
    assign wendFail = busErrorIn || aborted;
    assign burstSizeOut = 8'd0;

`ifdef UBM_BUS_TIMEOUT_EN
    logic [7:0] timeoutCount;
    assign timedOut = timeoutCount == TIMEOUT_CYCLES - 8'd1;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            timeoutCount <= '0;
        else
            timeoutCount <= (state == S_WDATA || state == S_RWAIT) ? timeoutCount + 8'd1 : '0;
    end
`else
    assign timedOut = 1'b0;
`endif

    // Every output is registered from the state being entered, so strobes line up with the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= S_IDLE;
            address             <= '0;
            wordData            <= '0;
            lanes               <= '0;
            isRead              <= 1'b0;
            gotData             <= 1'b0;
            aborted             <= 1'b0;
            cpuBusy             <= 1'b0;
            cpuDone             <= 1'b0;
            cpuError            <= 1'b0;
            readData            <= '0;
            requestBus          <= 1'b0;
            beginTransactionOut <= 1'b0;
            addressDataOut      <= '0;
            byteEnablesOut      <= '0;
            readNotWriteOut     <= 1'b0;
            dataValidOut        <= 1'b0;
            endTransactionOut   <= 1'b0;
        end else begin
            cpuDone             <= 1'b0;
            cpuError            <= 1'b0;
            beginTransactionOut <= 1'b0;
            addressDataOut      <= '0;
            byteEnablesOut      <= '0;
            readNotWriteOut     <= 1'b0;
            dataValidOut        <= 1'b0;
            endTransactionOut   <= 1'b0;
            case (state)
                S_IDLE: if (startRead || startWrite) begin
                    address    <= accessAddress;
                    lanes      <= byteEnables(accessSize, accessAddress[1:0]);
                    wordData   <= replicateData(accessSize, writeData);
                    isRead     <= startRead;
                    aborted    <= 1'b0;
                    state      <= badStart ? S_ERROR : S_REQUEST;
                    cpuError   <= badStart;
                    requestBus <= !badStart;
                    cpuBusy    <= !badStart;
                end
                S_REQUEST: if (busAccessGranted) begin
                    state               <= S_BEGIN;
                    requestBus          <= 1'b0;
                    beginTransactionOut <= 1'b1;
                    addressDataOut      <= {address[31:2], 2'b00};
                    byteEnablesOut      <= lanes;
                    readNotWriteOut     <= isRead;
                    gotData             <= 1'b0;
                end
                S_BEGIN: begin
                    state          <= busErrorIn ? S_ERROR : isRead ? S_RWAIT : S_WDATA;
                    cpuError       <= busErrorIn;
                    cpuBusy        <= !busErrorIn;
                    dataValidOut   <= !busErrorIn && !isRead;
                    addressDataOut <= (!busErrorIn && !isRead) ? wordData : '0;
                end
                S_WDATA: begin
                    if (busErrorIn) begin
                        state             <= S_ERROR;
                        cpuError          <= 1'b1;
                        cpuBusy           <= 1'b0;
                        endTransactionOut <= 1'b1;
                    end else if (!busyIn || timedOut) begin
                        state             <= S_WEND;
                        endTransactionOut <= 1'b1;
                        aborted           <= busyIn;
                    end else begin
                        dataValidOut   <= 1'b1;
                        addressDataOut <= wordData;
                    end
                end
                S_WEND: begin
                    state    <= wendFail ? S_ERROR : S_DONE;
                    cpuError <= wendFail;
                    cpuDone  <= !wendFail;
                    cpuBusy  <= 1'b0;
                end
                S_RWAIT: begin
                    if (dataValidIn) begin
                        readData <= addressDataIn;
                        gotData  <= 1'b1;
                    end
                    if (readFail || endTransactionIn) begin
                        state    <= readFail ? S_ERROR : S_DONE;
                        cpuError <= readFail;
                        cpuDone  <= !readFail;
                        cpuBusy  <= 1'b0;
                    end else if (timedOut) begin
                        state             <= S_WEND;
                        endTransactionOut <= 1'b1;
                        aborted           <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uncached_bus_master.sv
// tb_uncached_bus_master: directed scoreboard bench for uncached_bus_master.
// Define UBM_BUS_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=8.
module tb_uncached_bus_master;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        startRead = 1'b0;
    logic        startWrite = 1'b0;
    logic [31:0] accessAddress = '0;
    logic [1:0]  accessSize = '0;
    logic [31:0] writeData = '0;
    logic        busAccessGranted = 1'b0;
    logic        busErrorIn = 1'b0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic        busyIn = 1'b0;
    logic [31:0] addressDataIn = '0;
    logic        cpuBusy, cpuDone, cpuError, requestBus, beginTransactionOut;
    logic        readNotWriteOut, dataValidOut, endTransactionOut;
    logic [31:0] readData, addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;

`ifdef UBM_BUS_TIMEOUT_EN
    uncached_bus_master #(.TIMEOUT_CYCLES(8'd8)) dut (
        .clock(clock), .reset(reset),
        .startRead(startRead), .startWrite(startWrite),
        .accessAddress(accessAddress), .accessSize(accessSize), .writeData(writeData),
        .cpuBusy(cpuBusy), .cpuDone(cpuDone), .cpuError(cpuError), .readData(readData),
        .requestBus(requestBus), .busAccessGranted(busAccessGranted),
        .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
        .byteEnablesOut(byteEnablesOut), .readNotWriteOut(readNotWriteOut),
        .burstSizeOut(burstSizeOut), .dataValidOut(dataValidOut),
        .endTransactionOut(endTransactionOut), .busErrorIn(busErrorIn),
        .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn),
        .busyIn(busyIn), .addressDataIn(addressDataIn)
    );
`else
    uncached_bus_master dut (
        .clock(clock), .reset(reset),
        .startRead(startRead), .startWrite(startWrite),
        .accessAddress(accessAddress), .accessSize(accessSize), .writeData(writeData),
        .cpuBusy(cpuBusy), .cpuDone(cpuDone), .cpuError(cpuError), .readData(readData),
        .requestBus(requestBus), .busAccessGranted(busAccessGranted),
        .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
        .byteEnablesOut(byteEnablesOut), .readNotWriteOut(readNotWriteOut),
        .burstSizeOut(burstSizeOut), .dataValidOut(dataValidOut),
        .endTransactionOut(endTransactionOut), .busErrorIn(busErrorIn),
        .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn),
        .busyIn(busyIn), .addressDataIn(addressDataIn)
    );
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        rnw;
        logic [31:0] wdata;
    } busExp_t;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } respExp_t;

    busExp_t     busQ[$];
    respExp_t    respQ[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cycleCount = 0;
    int          startCycle = 0;
    int          endCycle = 0;
    int          dvCount = 0;
    logic        sawRequest = 1'b0;
    logic [31:0] pendWdata = '0;

    always @(posedge clock) cycleCount++;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ctlOuts();
        return {12'd0, cpuBusy, cpuDone, cpuError, requestBus, beginTransactionOut, byteEnablesOut,
                readNotWriteOut, burstSizeOut, dataValidOut, endTransactionOut};
    endfunction

    task automatic expBus(input logic [31:0] addr, input logic [3:0] be, input logic rnw, input logic [31:0] wdata);
        busQ.push_back('{addr, be, rnw, wdata});
    endtask

    task automatic expResp(input logic err, input logic chk, input logic [31:0] data);
        respQ.push_back('{err, chk, data});
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (requestBus) sawRequest = 1'b1;
            if (dataValidOut) begin
                dvCount++;
                check("writeData", addressDataOut, pendWdata);
            end
            if (!beginTransactionOut) begin
                check("wiredOrLanes", {19'd0, byteEnablesOut, readNotWriteOut, burstSizeOut}, 32'd0);
                if (!dataValidOut) check("wiredOrAd", addressDataOut, 32'd0);
            end else if (busQ.size() == 0) begin
                check("unexpectedBegin", 32'd1, 32'd0);
            end else begin
                busExp_t b;
                b = busQ.pop_front();
                check("beginAddr", addressDataOut, b.addr);
                check("beginLanes", 32'(byteEnablesOut), 32'(b.be));
                check("beginRnw", 32'(readNotWriteOut), 32'(b.rnw));
                check("beginBurst", 32'(burstSizeOut), 32'd0);
                pendWdata = b.wdata;
            end
            if (cpuDone || cpuError) begin
                if (respQ.size() == 0) begin
                    check("unexpectedResp", 32'd1, 32'd0);
                end else begin
                    respExp_t r;
                    r = respQ.pop_front();
                    check("respError", 32'(cpuError), 32'(r.err));
                    check("respDone", 32'(cpuDone), 32'(!r.err));
                    if (r.chk) check("readData", readData, r.data);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic startOp(input logic rd, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] data);
        startRead = rd;
        startWrite = wr;
        accessSize = size;
        accessAddress = addr;
        writeData = data;
        startCycle = cycleCount;
        step(1);
        startRead = 1'b0;
        startWrite = 1'b0;
        accessSize = 2'b00;
        accessAddress = '1;
        writeData = '1;
    endtask

    task automatic waitBegin(input string tag);
        int i;
        for (i = 0; i < 20; i++) begin
            @(negedge clock);
            if (beginTransactionOut) break;
        end
        if (i == 20) check(tag, 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic waitEnd(input string tag);
        int i;
        for (i = 0; i < 30; i++) begin
            @(negedge clock);
            if (cpuDone || cpuError) break;
        end
        if (i == 30) check(tag, 32'd0, 32'd1);
        endCycle = cycleCount;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  badSize [3] = '{2'b10, 2'b11, 2'b00};
        logic [31:0] badAddr [3] = '{32'h4000_0001, 32'h4000_0002, 32'h4000_0000};
        step(2);
        check("resetCtl", ctlOuts(), 32'd0);
        check("resetAd", addressDataOut, 32'd0);
        check("resetRd", readData, 32'd0);
        reset = 1'b1;
        step(1);

        expBus(32'h4000_0000, 4'b0001, 1'b0, 32'hABAB_ABAB);
        expResp(1'b0, 1'b0, '0);
        startOp(1'b0, 1'b1, 2'b01, 32'h4000_0003, 32'h0000_00AB);
        check("reqHeld", 32'(requestBus), 32'd1);
        check("busyReq", 32'(cpuBusy), 32'd1);
        step(1);
        busAccessGranted = 1'b1;
        step(1);
        busAccessGranted = 1'b0;
        check("beginStrobe", 32'(beginTransactionOut), 32'd1);
        check("reqDropped", 32'(requestBus), 32'd0);
        waitEnd("byteStoreEnd");
        check("byteStoreLatency", 32'(endCycle - startCycle), 32'd6);
        busAccessGranted = 1'b1;

        expBus(32'h4000_0010, 4'b1111, 1'b1, '0);
        expResp(1'b0, 1'b1, 32'hDEAD_BEEF);
        startOp(1'b1, 1'b0, 2'b11, 32'h4000_0010, '0);
        waitBegin("wordLoadBegin");
        dataValidIn = 1'b1;
        endTransactionIn = 1'b1;
        addressDataIn = 32'hDEAD_BEEF;
        step(1);
        dataValidIn = 1'b0;
        endTransactionIn = 1'b0;
        addressDataIn = '0;
        check("loadDone", 32'(cpuDone), 32'd1);
        check("loadBusyLow", 32'(cpuBusy), 32'd0);
        waitEnd("wordLoadEnd");

        sawRequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expResp(1'b1, 1'b0, '0);
            startOp(1'b0, 1'b1, badSize[k], badAddr[k], 32'h1234_5678);
            check("badStartError", 32'(cpuError), 32'd1);
            check("badStartBusy", 32'(cpuBusy), 32'd0);
            step(1);
        end
        check("badStartNoRequest", 32'(sawRequest), 32'd0);

        expBus(32'h4000_0000, 4'b0011, 1'b0, 32'h1234_1234);
        expResp(1'b0, 1'b0, '0);
        startOp(1'b0, 1'b1, 2'b10, 32'h4000_0002, 32'h0000_1234);
        waitBegin("busyBegin");
        dvCount = 0;
        busyIn = 1'b1;
        startRead = 1'b1;
        accessSize = 2'b11;
        accessAddress = 32'h4000_0100;
        step(1);
        startRead = 1'b0;
        step(2);
        busyIn = 1'b0;
        check("dataHeld", 32'(dataValidOut), 32'd1);
        step(1);
        check("wendStrobe", 32'(endTransactionOut), 32'd1);
        check("wendNoData", 32'(dataValidOut), 32'd0);
        waitEnd("busyEnd");
        check("dataValidCycles", 32'(dvCount), 32'd4);

        expBus(32'h4000_0000, 4'b0010, 1'b1, '0);
        expResp(1'b0, 1'b1, 32'hCAFE_F00D);
        startOp(1'b1, 1'b1, 2'b01, 32'h4000_0002, 32'h0000_0055);
        waitBegin("splitBegin");
        dataValidIn = 1'b1;
        addressDataIn = 32'hCAFE_F00D;
        step(1);
        dataValidIn = 1'b0;
        addressDataIn = 32'h0BAD_BAD0;
        step(1);
        endTransactionIn = 1'b1;
        step(1);
        endTransactionIn = 1'b0;
        addressDataIn = '0;
        waitEnd("splitEnd");

        expBus(32'h4000_0004, 4'b1111, 1'b1, '0);
        expResp(1'b1, 1'b0, '0);
        startOp(1'b1, 1'b0, 2'b11, 32'h4000_0004, '0);
        waitBegin("noDataBegin");
        endTransactionIn = 1'b1;
        step(1);
        endTransactionIn = 1'b0;
        waitEnd("noDataEnd");

        expBus(32'h4000_0020, 4'b0100, 1'b1, '0);
        expResp(1'b1, 1'b0, '0);
        startOp(1'b1, 1'b0, 2'b01, 32'h4000_0021, '0);
        waitBegin("busErrBegin");
        busErrorIn = 1'b1;
        step(1);
        busErrorIn = 1'b0;
        check("busErrPulse", 32'(cpuError), 32'd1);
        step(1);
        check("busErrIdleCtl", ctlOuts(), 32'd0);
        check("busErrIdleAd", addressDataOut, 32'd0);

        expBus(32'h4000_0008, 4'b1111, 1'b0, 32'h1122_3344);
        startOp(1'b0, 1'b1, 2'b11, 32'h4000_0008, 32'h1122_3344);
        waitBegin("resetBegin");
        busyIn = 1'b1;
        check("resetPreData", 32'(dataValidOut), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midResetCtl", ctlOuts(), 32'd0);
        check("midResetAd", addressDataOut, 32'd0);
        check("midResetRd", readData, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        busyIn = 1'b0;
        step(1);
        check("postResetCtl", ctlOuts(), 32'd0);

`ifdef UBM_BUS_TIMEOUT_EN
        begin
            int i;
            expBus(32'h4000_0030, 4'b1111, 1'b1, '0);
            expResp(1'b1, 1'b0, '0);
            startOp(1'b1, 1'b0, 2'b11, 32'h4000_0030, '0);
            waitBegin("timeoutBegin");
            for (i = 0; i < 20; i++) begin
                @(negedge clock);
                if (endTransactionOut) break;
            end
            check("timeoutCycles", 32'(i), 32'd8);
            @(posedge clock);
            #1;
            check("timeoutError", 32'(cpuError), 32'd1);
            check("timeoutEndDropped", 32'(endTransactionOut), 32'd0);
            step(1);
        end
`endif

        check("busQueueDrained", 32'(busQ.size()), 32'd0);
        check("respQueueDrained", 32'(respQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
